// File: rtl/alu_multicycle_if.sv
// Issue/writeback handshake bundle for alu_multicycle: request side (operands,
// opcode, in_valid/in_ready) and result side (result, flags, out_valid/out_ready).
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             CarryOut;
    logic             Zero;
    logic             Overflow;
    logic             Negative;

    // Producer/consumer side: issues operations and accepts results.
    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, Result, CarryOut, Zero, Overflow, Negative
    );

    // ALU side.
    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, Result, CarryOut, Zero, Overflow, Negative
    );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU with registered result/flags. Simple ops finish in one cycle;
// MULU (shift-add) and DIVU/REMU (restoring division) take WIDTH iterations.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    alu_multicycle_if.slave bus
);

    localparam int unsigned IterW = $clog2(WIDTH);
    localparam logic [IterW-1:0] IterLast = IterW'(WIDTH - 1);

    localparam logic [WIDTH-1:0] AllOnes = '1;
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MaxPos  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpInc  = 4'b0010;
    localparam logic [3:0] OpDec  = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpOr   = 4'b0101;
    localparam logic [3:0] OpXor  = 4'b0110;
    localparam logic [3:0] OpNot  = 4'b0111;
    localparam logic [3:0] OpLsl  = 4'b1000;
    localparam logic [3:0] OpLsr  = 4'b1001;
    localparam logic [3:0] OpAsr  = 4'b1010;
    localparam logic [3:0] OpRol  = 4'b1011;
    localparam logic [3:0] OpMulu = 4'b1100;
    localparam logic [3:0] OpDivu = 4'b1101;
    localparam logic [3:0] OpRemu = 4'b1110;
    localparam logic [3:0] OpCmp  = 4'b1111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;
    logic [IterW-1:0] iter_q, iter_d;

    // Captured request.
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;

    // Iterative datapath: multiply accumulator and divider state.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;

    // Registered outputs.
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;

    logic accept, is_multi, load, step, finish_sc, finish_mc;

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.Result    = result_q;
    assign bus.CarryOut  = carry_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Negative  = neg_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_multi = (bus.opcode == OpMulu) || (bus.opcode == OpDivu)
                   || (bus.opcode == OpRemu);

    // ---------------------------------------------------------------------
    // Single-cycle operations, evaluated directly on the request inputs.
    // ---------------------------------------------------------------------
    logic [WIDTH:0]   add_sum, sub_diff;
    logic             a_msb, b_msb, sub_ovf;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_z, sc_n;

    assign add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
    assign a_msb    = bus.A[WIDTH-1];
    assign b_msb    = bus.B[WIDTH-1];
    assign sub_ovf  = (a_msb != b_msb) && (sub_diff[WIDTH-1] != a_msb);

    // Result and carry/overflow for the one-cycle opcodes.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (bus.opcode)
            OpAdd: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (a_msb == b_msb) && (add_sum[WIDTH-1] != a_msb);
            end
            OpSub: begin
                sc_res = sub_diff[WIDTH-1:0];
                sc_c   = sub_diff[WIDTH];
                sc_v   = sub_ovf;
            end
            OpInc: begin
                sc_res = bus.A + One;
                sc_c   = (bus.A == AllOnes);
                sc_v   = (bus.A == MaxPos);
            end
            OpDec: begin
                sc_res = bus.A - One;
                sc_c   = (bus.A == '0);
                sc_v   = (bus.A == MinNeg);
            end
            OpAnd: sc_res = bus.A & bus.B;
            OpOr:  sc_res = bus.A | bus.B;
            OpXor: sc_res = bus.A ^ bus.B;
            OpNot: sc_res = ~bus.A;
            OpLsl: begin
                sc_res = {bus.A[WIDTH-2:0], 1'b0};
                sc_c   = a_msb;
            end
            OpLsr: begin
                sc_res = {1'b0, bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
            OpAsr: begin
                sc_res = {a_msb, bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
            OpRol: begin
                sc_res = {bus.A[WIDTH-2:0], a_msb};
                sc_c   = a_msb;
            end
            OpCmp: begin
                // Flags only; the result stays zero.
                sc_c = sub_diff[WIDTH];
                sc_v = sub_ovf;
            end
            default: ;
        endcase
    end

    assign sc_z = (bus.opcode == OpCmp) ? (bus.A == bus.B) : (sc_res == '0);
    assign sc_n = (bus.opcode == OpCmp) ? sub_diff[WIDTH-1] : sc_res[WIDTH-1];

    // ---------------------------------------------------------------------
    // Iterative multiply / divide step.
    // ---------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff, rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               unused_rem_msb;

    // Upper half of acc accumulates; lower half holds the remaining multiplier bits.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring division: shift in the next dividend bit, keep the difference if it
    // did not go negative. With B==0 every trial succeeds, giving all-ones / A.
    assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign rem_next  = div_diff[WIDTH] ? div_shift : div_diff;
    assign quo_next  = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    // The partial remainder never exceeds WIDTH bits between steps.
    assign unused_rem_msb = rem_q[WIDTH];

    logic [WIDTH-1:0] mc_res;
    logic             mc_c, mc_v;

    // Final result of the multi-cycle op, taken from the last step's next state.
    always_comb begin
        mc_res = '0;
        mc_c   = 1'b0;
        mc_v   = 1'b0;
        case (op_q)
            OpMulu: begin
                mc_res = mul_next[WIDTH-1:0];
                mc_c   = |mul_next[2*WIDTH-1:WIDTH];
            end
            OpDivu: begin
                mc_res = (b_q == '0) ? AllOnes : quo_next;
                mc_v   = (b_q == '0);
            end
            OpRemu: begin
                mc_res = (b_q == '0) ? a_q : rem_next[WIDTH-1:0];
                mc_v   = (b_q == '0);
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM.
    // ---------------------------------------------------------------------

    // Next-state and datapath strobes.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        load      = 1'b0;
        step      = 1'b0;
        finish_sc = 1'b0;
        finish_mc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    load   = 1'b1;
                    iter_d = '0;
                    if (is_multi) begin
                        state_d = StBusy;
                    end else begin
                        state_d   = StDone;
                        finish_sc = 1'b1;
                    end
                end
            end
            StBusy: begin
                step = 1'b1;
                if (iter_q == IterLast) begin
                    state_d   = StDone;
                    finish_mc = 1'b1;
                    iter_d    = '0;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Capture operands on accept and advance the iterative units while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= bus.opcode;
            acc_q <= {{WIDTH{1'b0}}, bus.B};
            rem_q <= '0;
            quo_q <= bus.A;
        end else if (step) begin
            acc_q <= mul_next;
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

    // Select which unit's result lands in the output registers.
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        if (finish_sc) begin
            result_d = sc_res;
            carry_d  = sc_c;
            zero_d   = sc_z;
            ovf_d    = sc_v;
            neg_d    = sc_n;
        end else if (finish_mc) begin
            result_d = mc_res;
            carry_d  = mc_c;
            zero_d   = (mc_res == '0);
            ovf_d    = mc_v;
            neg_d    = mc_res[WIDTH-1];
        end
    end

    // Result/flag registers; only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table at WIDTH=8, plus backpressure,
// mid-operation reset and a WIDTH=16 multiply.
module tb_alu_multicycle;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(8))  if8 ();
    alu_multicycle_if #(.WIDTH(16)) if16 ();

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       n;
        int         lat;
    } vec_t;

    localparam int NumVec = 26;
    vec_t vecs[NumVec];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op on the 8-bit DUT, wait for the result, then complete the handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          output logic [7:0] res, output logic c, output logic z,
                          output logic v, output logic n, output int lat,
                          output int busy_ready);
        if8.A        = a;
        if8.B        = b;
        if8.opcode   = op;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        lat        = 1;
        busy_ready = 0;
        while (!if8.out_valid && lat < 100) begin
            if (if8.in_ready) busy_ready++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = if8.Result;
        c   = if8.CarryOut;
        z   = if8.Zero;
        v   = if8.Overflow;
        n   = if8.Negative;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
    endtask

    logic [7:0] r;
    logic       fc, fz, fv, fn;
    int         lat, br, pulses;

    initial begin
        // {a, b, op, res, c, z, v, n, latency}
        vecs[0]  = '{8'h7F, 8'h01, 4'b0000, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1}; // ADD ovf
        vecs[1]  = '{8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1}; // ADD carry
        vecs[2]  = '{8'h05, 8'h07, 4'b0001, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1}; // SUB borrow
        vecs[3]  = '{8'h80, 8'h01, 4'b0001, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1}; // SUB ovf
        vecs[4]  = '{8'hFF, 8'h00, 4'b0010, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1}; // INC wrap
        vecs[5]  = '{8'h7F, 8'h00, 4'b0010, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1}; // INC ovf
        vecs[6]  = '{8'h00, 8'h00, 4'b0011, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1}; // DEC wrap
        vecs[7]  = '{8'h80, 8'h00, 4'b0011, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1}; // DEC ovf
        vecs[8]  = '{8'hF0, 8'h3C, 4'b0100, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // AND
        vecs[9]  = '{8'h0F, 8'hA0, 4'b0101, 8'hAF, 1'b0, 1'b0, 1'b0, 1'b1, 1}; // OR
        vecs[10] = '{8'hAA, 8'hAA, 4'b0110, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // XOR
        vecs[11] = '{8'h0F, 8'h00, 4'b0111, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1}; // NOT
        vecs[12] = '{8'h81, 8'h00, 4'b1000, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // LSL
        vecs[13] = '{8'h81, 8'h00, 4'b1001, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // LSR
        vecs[14] = '{8'h81, 8'h00, 4'b1010, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1}; // ASR
        vecs[15] = '{8'h81, 8'h00, 4'b1011, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // ROL
        vecs[16] = '{8'h10, 8'h11, 4'b1100, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 9}; // MULU hi!=0
        vecs[17] = '{8'h0F, 8'h0F, 4'b1100, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1, 9}; // MULU
        vecs[18] = '{8'hC8, 8'h07, 4'b1101, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 9}; // DIVU
        vecs[19] = '{8'hC8, 8'h07, 4'b1110, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 9}; // REMU
        vecs[20] = '{8'h55, 8'h00, 4'b1101, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 9}; // DIVU /0
        vecs[21] = '{8'h55, 8'h00, 4'b1110, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 9}; // REMU /0
        vecs[22] = '{8'h05, 8'h05, 4'b1111, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // CMP eq
        vecs[23] = '{8'h03, 8'h05, 4'b1111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1}; // CMP lt
        vecs[24] = '{8'h80, 8'h01, 4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1}; // CMP ovf
        vecs[25] = '{8'h07, 8'hC8, 4'b1101, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9}; // DIVU q=0

        if8.in_valid   = 1'b0;
        if8.A          = '0;
        if8.B          = '0;
        if8.opcode     = '0;
        if8.out_ready  = 1'b0;
        if16.in_valid  = 1'b0;
        if16.A         = '0;
        if16.B         = '0;
        if16.opcode    = '0;
        if16.out_ready = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'b0, if8.in_ready}, 32'h0);
        chk("reset out_valid", {31'b0, if8.out_valid}, 32'h0);
        chk("reset result", {24'b0, if8.Result}, 32'h0);
        chk("reset flags", {28'b0, if8.CarryOut, if8.Zero, if8.Overflow, if8.Negative},
            32'h0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", {31'b0, if8.in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Vector table.
        for (int i = 0; i < NumVec; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, fc, fz, fv, fn, lat, br);
            chk($sformatf("v%0d result", i), {24'b0, r}, {24'b0, vecs[i].res});
            chk($sformatf("v%0d flags czvn", i), {28'b0, fc, fz, fv, fn},
                {28'b0, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].n});
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d in_ready while busy", i), br, 0);
            chk($sformatf("v%0d out_valid after handshake", i), {31'b0, if8.out_valid}, 0);
            chk($sformatf("v%0d in_ready after handshake", i), {31'b0, if8.in_ready}, 1);
        end

        // Backpressure: outputs hold while out_ready is low and inputs wiggle.
        if8.A        = 8'h7F;
        if8.B        = 8'h01;
        if8.opcode   = 4'b0000;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            if8.A      = 8'h11 * k[7:0];
            if8.B      = ~if8.A;
            if8.opcode = 4'(k + 3);
            chk($sformatf("bp%0d out_valid", k), {31'b0, if8.out_valid}, 1);
            chk($sformatf("bp%0d result", k), {24'b0, if8.Result}, 32'h80);
            chk($sformatf("bp%0d flags czvn", k),
                {28'b0, if8.CarryOut, if8.Zero, if8.Overflow, if8.Negative}, 32'b0011);
            chk($sformatf("bp%0d in_ready", k), {31'b0, if8.in_ready}, 0);
            @(posedge clk);
            #1;
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
        chk("bp release out_valid", {31'b0, if8.out_valid}, 0);
        chk("bp release in_ready", {31'b0, if8.in_ready}, 1);
        chk("bp release result kept", {24'b0, if8.Result}, 32'h80);

        // Reset during iteration 4 of a MULU aborts it.
        if8.A        = 8'h10;
        if8.B        = 8'h11;
        if8.opcode   = 4'b1100;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-reset out_valid", {31'b0, if8.out_valid}, 0);
        chk("mid-reset result", {24'b0, if8.Result}, 0);
        chk("mid-reset in_ready during rst", {31'b0, if8.in_ready}, 0);
        rst = 1'b0;
        #1;
        chk("mid-reset in_ready after rst", {31'b0, if8.in_ready}, 1);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (if8.out_valid) pulses++;
        end
        chk("mid-reset no out_valid pulse", pulses, 0);
        run_op(8'h81, 8'h00, 4'b1011, r, fc, fz, fv, fn, lat, br);
        chk("post-reset ROL result", {24'b0, r}, 32'h03);
        chk("post-reset ROL carry", {31'b0, fc}, 1);

        // WIDTH=16 multiply: 0x0100 * 0x0100 overflows entirely into the high half.
        if16.A        = 16'h0100;
        if16.B        = 16'h0100;
        if16.opcode   = 4'b1100;
        if16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if16.in_valid = 1'b0;
        lat = 1;
        br  = 0;
        while (!if16.out_valid && lat < 100) begin
            if (if16.in_ready) br++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w16 latency", lat, 17);
        chk("w16 in_ready while busy", br, 0);
        chk("w16 result", {16'b0, if16.Result}, 32'h0);
        chk("w16 flags czvn",
            {28'b0, if16.CarryOut, if16.Zero, if16.Overflow, if16.Negative}, 32'b1100);
        if16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if16.out_ready = 1'b0;
        chk("w16 out_valid after handshake", {31'b0, if16.out_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
